// File: rtl/retire_trace_tx.sv
// Retirement trace transmitter: stamps wb/store retire events, queues them, drains over valid/ready.
// Optional macro TRACE_FILTER_X0_EN drops writebacks to x0 before they reach the FIFO.
module retire_trace_tx #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 16,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h1000_0000,
    parameter int              WDOG_LIMIT  = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    input  logic            wb_pc_load,
    input  logic [XLEN-1:0] wb_tag,
    input  logic [31:0]     wb_instr,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] wb_pc,
    input  logic            st0_valid,
    input  logic [XLEN-1:0] st0_tag,
    input  logic [31:0]     st0_instr,
    input  logic [XLEN-1:0] st0_addr,
    input  logic [XLEN-1:0] st0_data,
    input  logic            st1_valid,
    input  logic [XLEN-1:0] st1_tag,
    input  logic [31:0]     st1_instr,
    input  logic [XLEN-1:0] st1_addr,
    input  logic [XLEN-1:0] st1_data,
    output logic            tr_valid,
    input  logic            tr_ready,
    output logic [1:0]      tr_kind,
    output logic [31:0]     tr_cycle,
    output logic [XLEN-1:0] tr_tag,
    output logic [31:0]     tr_instr,
    output logic [XLEN-1:0] tr_addr,
    output logic [XLEN-1:0] tr_data,
    output logic [XLEN-1:0] tr_pc,
    output logic            finish,
    output logic            abort,
    output logic            overflow,
    output logic            drained
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int WW = $clog2(WDOG_LIMIT + 1);

    typedef struct packed {
        logic [1:0]      kind;
        logic [31:0]     cycle;
        logic [XLEN-1:0] tag;
        logic [31:0]     instr;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } rec_t;

    typedef enum logic [1:0] {S_RUN, S_DONE, S_ABORT} state_t;

    state_t         state_reg;
    logic           finish_reg, abort_reg, overflow_reg;
    logic [WW-1:0]  wdog_reg;
    logic [31:0]    cycle_reg;
    logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
    rec_t           mem [DEPTH];

    logic           wb_take;
    logic [2:0]     ev_v;
    rec_t           ev_rec [3];
    logic [PW-1:0]  ev_off [3];
    logic [AW-1:0]  wr_idx [3];
    logic [1:0]     ev_cnt;
    logic [PW-1:0]  used_cnt, free_cnt;
    logic           in_run, do_enq, drop, empty, pop, tohost, any_ev, wdog_hit;
    rec_t           head;

`ifdef TRACE_FILTER_X0_EN
    assign wb_take = wb_valid && (wb_rd != 5'd0);
`else
    assign wb_take = wb_valid;
`endif

    assign ev_v = {st1_valid, st0_valid, wb_take};

    assign ev_rec[0] = '{kind: wb_pc_load ? 2'd1 : 2'd0, cycle: cycle_reg, tag: wb_tag,
                         instr: wb_instr, addr: {{(XLEN-5){1'b0}}, wb_rd}, data: wb_data,
                         pc: wb_pc_load ? wb_pc : '0};
    assign ev_rec[1] = '{kind: 2'd2, cycle: cycle_reg, tag: st0_tag, instr: st0_instr,
                         addr: st0_addr, data: st0_data, pc: '0};
    assign ev_rec[2] = '{kind: 2'd2, cycle: cycle_reg, tag: st1_tag, instr: st1_instr,
                         addr: st1_addr, data: st1_data, pc: '0};

    // Valid events are packed into consecutive slots starting at the write pointer.
    assign ev_off[0] = '0;
    assign ev_off[1] = PW'(ev_v[0]);
    assign ev_off[2] = PW'(ev_v[0]) + PW'(ev_v[1]);
    assign ev_cnt    = {1'b0, ev_v[0]} + {1'b0, ev_v[1]} + {1'b0, ev_v[2]};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_idx
            logic [PW-1:0] slot;
            assign slot       = wr_ptr_reg + ev_off[gi];
            assign wr_idx[gi] = slot[AW-1:0];
        end
    endgenerate

    // Space is judged against occupancy before this cycle's pop.
    assign used_cnt = wr_ptr_reg - rd_ptr_reg;
    assign free_cnt = PW'(DEPTH) - used_cnt;
    assign in_run   = (state_reg == S_RUN);
    assign do_enq   = in_run && (ev_cnt != 2'd0) && (PW'(ev_cnt) <= free_cnt);
    assign drop     = in_run && (ev_cnt != 2'd0) && (PW'(ev_cnt) > free_cnt);
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign tr_valid = ~empty;
    assign pop      = tr_valid && tr_ready;
    assign tohost   = (st0_valid && st0_addr == TOHOST_ADDR) || (st1_valid && st1_addr == TOHOST_ADDR);
    assign any_ev   = wb_valid || st0_valid || st1_valid;
    assign wdog_hit = (wdog_reg == WW'(WDOG_LIMIT));

    always_ff @(posedge clk) begin
        if (do_enq) begin
            for (int i = 0; i < 3; i++) begin
                if (ev_v[i]) mem[wr_idx[i]] <= ev_rec[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_RUN;
            finish_reg   <= 1'b0;
            abort_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            wdog_reg     <= '0;
            cycle_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
            if (pop)    rd_ptr_reg   <= rd_ptr_reg + PW'(1);
            if (do_enq) wr_ptr_reg   <= wr_ptr_reg + PW'(ev_cnt);
            if (drop)   overflow_reg <= 1'b1;
            case (state_reg)
                S_RUN: begin
                    if (tohost) begin
                        state_reg  <= S_DONE;
                        finish_reg <= 1'b1;
                    end else if (wdog_hit) begin
                        state_reg <= S_ABORT;
                        abort_reg <= 1'b1;
                    end
                    if (any_ev)         wdog_reg <= '0;
                    else if (!wdog_hit) wdog_reg <= wdog_reg + WW'(1);
                end
                default: ;
            endcase
        end
    end

    // Head fields are forced to zero when nothing is queued so stale storage never leaks out.
    assign head     = mem[rd_ptr_reg[AW-1:0]];
    assign tr_kind  = tr_valid ? head.kind  : '0;
    assign tr_cycle = tr_valid ? head.cycle : '0;
    assign tr_tag   = tr_valid ? head.tag   : '0;
    assign tr_instr = tr_valid ? head.instr : '0;
    assign tr_addr  = tr_valid ? head.addr  : '0;
    assign tr_data  = tr_valid ? head.data  : '0;
    assign tr_pc    = tr_valid ? head.pc    : '0;
    assign finish   = finish_reg;
    assign abort    = abort_reg;
    assign overflow = overflow_reg;
    assign drained  = !in_run && empty;
endmodule

// File: tb/tb_retire_trace_tx.sv
// Self-checking bench for retire_trace_tx: directed scenarios plus random traffic against a queue model.
module tb_retire_trace_tx;
    localparam int          DEPTH  = 16;
    localparam int          WLIM   = 1000;
    localparam logic [31:0] TOHOST = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, wb_pc_load;
    logic [31:0] wb_tag, wb_instr, wb_data, wb_pc;
    logic [4:0]  wb_rd;
    logic        st0_valid, st1_valid;
    logic [31:0] st0_tag, st0_instr, st0_addr, st0_data;
    logic [31:0] st1_tag, st1_instr, st1_addr, st1_data;
    logic        tr_valid, tr_ready;
    logic [1:0]  tr_kind;
    logic [31:0] tr_cycle, tr_tag, tr_instr, tr_addr, tr_data, tr_pc;
    logic        finish, abort, overflow, drained;

    retire_trace_tx dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_pc_load(wb_pc_load), .wb_tag(wb_tag), .wb_instr(wb_instr),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
        .st0_valid(st0_valid), .st0_tag(st0_tag), .st0_instr(st0_instr), .st0_addr(st0_addr), .st0_data(st0_data),
        .st1_valid(st1_valid), .st1_tag(st1_tag), .st1_instr(st1_instr), .st1_addr(st1_addr), .st1_data(st1_data),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_kind(tr_kind), .tr_cycle(tr_cycle), .tr_tag(tr_tag),
        .tr_instr(tr_instr), .tr_addr(tr_addr), .tr_data(tr_data), .tr_pc(tr_pc),
        .finish(finish), .abort(abort), .overflow(overflow), .drained(drained)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cycle, tag, instr, addr, data, pc;
    } rec_t;

    // Reference model: a plain queue of expected records plus a few status flags.
    rec_t        q[$];
    logic [31:0] m_cycle;
    int          m_wdog;
    bit          m_done, m_abort, m_ovf;
    int          total = 0, bad = 0, n_pop = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        wb_valid = 0; wb_pc_load = 0; wb_tag = 0; wb_instr = 0; wb_rd = 0; wb_data = 0; wb_pc = 0;
        st0_valid = 0; st0_tag = 0; st0_instr = 0; st0_addr = 0; st0_data = 0;
        st1_valid = 0; st1_tag = 0; st1_instr = 0; st1_addr = 0; st1_data = 0;
    endtask

    task automatic model_clear();
        q.delete();
        m_cycle = 0; m_wdog = 0; m_done = 0; m_abort = 0; m_ovf = 0;
    endtask

    // Check outputs against the model, advance the model by one cycle, then cross a clock edge.
    task automatic tick();
        rec_t ev[$];
        rec_t e;
        int   sz;
        bit   hit;
        sz = q.size();
        chk("tr_valid", tr_valid, sz != 0);
        if (sz != 0) begin
            e = q[0];
            chk("tr_kind", tr_kind, e.kind);   chk("tr_cycle", tr_cycle, e.cycle);
            chk("tr_tag", tr_tag, e.tag);      chk("tr_instr", tr_instr, e.instr);
            chk("tr_addr", tr_addr, e.addr);   chk("tr_data", tr_data, e.data);
            chk("tr_pc", tr_pc, e.pc);
        end
        chk("finish", finish, m_done);
        chk("abort", abort, m_abort);
        chk("overflow", overflow, m_ovf);
        chk("drained", drained, (m_done || m_abort) && sz == 0);
        if (tr_valid && tr_ready) begin
            n_pop++;
            $display("rec kind=%0d cycle=%0d tag=%h addr=%h data=%h pc=%h",
                     tr_kind, tr_cycle, tr_tag, tr_addr, tr_data, tr_pc);
        end
        if (sz != 0 && tr_ready) void'(q.pop_front());
        if (!m_done && !m_abort) begin
            hit = 1;
`ifdef TRACE_FILTER_X0_EN
            hit = (wb_rd != 0);
`endif
            if (wb_valid && hit)
                ev.push_back('{wb_pc_load ? 2'd1 : 2'd0, m_cycle, wb_tag, wb_instr, {27'b0, wb_rd},
                               wb_data, wb_pc_load ? wb_pc : 32'h0});
            if (st0_valid) ev.push_back('{2'd2, m_cycle, st0_tag, st0_instr, st0_addr, st0_data, 32'h0});
            if (st1_valid) ev.push_back('{2'd2, m_cycle, st1_tag, st1_instr, st1_addr, st1_data, 32'h0});
            if (ev.size() > DEPTH - sz) m_ovf = 1;
            else foreach (ev[i]) q.push_back(ev[i]);
            if ((st0_valid && st0_addr == TOHOST) || (st1_valid && st1_addr == TOHOST)) m_done = 1;
            else if (m_wdog == WLIM) m_abort = 1;
            if (wb_valid || st0_valid || st1_valid) m_wdog = 0;
            else if (m_wdog < WLIM) m_wdog++;
        end
        m_cycle++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        set_idle();
        @(posedge clk); @(negedge clk);
        chk("rst_tr_valid", tr_valid, 0);
        chk("rst_flags", {finish, abort, overflow, drained}, 4'b0000);
        @(posedge clk); @(negedge clk);
        chk("rst_tr_data", tr_data, 0);
        rst_n = 1;
        model_clear();
    endtask

    initial begin
        int cnt;
        tr_ready = 1;
        model_clear();
        @(negedge clk);

        // 1: single writeback at cycle 3
        do_reset();
        repeat (3) tick();
        wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; wb_tag = 32'h80; wb_instr = 32'h00500293;
        tick();
        set_idle();
        chk("t1_kind", tr_kind, 0); chk("t1_addr", tr_addr, 5);
        chk("t1_data", tr_data, 32'hDEADBEEF); chk("t1_cycle", tr_cycle, 3);
        tick();

        // 2: three events in one cycle, plus a jal-style REG_PC
        wb_valid = 1; wb_rd = 1; wb_data = 32'h11; wb_pc_load = 1; wb_pc = 32'h200;
        st0_valid = 1; st0_addr = 32'h100; st0_data = 32'hAA;
        st1_valid = 1; st1_addr = 32'h104; st1_data = 32'hBB;
        tick();
        set_idle();
        chk("t2_kind0", tr_kind, 1); chk("t2_pc0", tr_pc, 32'h200);
        tick();
        chk("t2_addr1", tr_addr, 32'h100);
        tick();
        chk("t2_addr2", tr_addr, 32'h104);
        repeat (2) tick();

        // 3: backpressure, fill to 16, then an all-or-none drop
        tr_ready = 0;
        for (int i = 0; i < 16; i++) begin
            wb_valid = 1; wb_rd = 5'(i + 1); wb_data = 32'(i);
            tick();
        end
        st0_valid = 1; st0_addr = 32'h300;
        tick();
        set_idle();
        chk("t3_ovf", overflow, 1);
        tr_ready = 1;
        n_pop = 0;
        repeat (20) tick();
        chk("t3_count", n_pop, 16);

        // 4: tohost finish, later writeback ignored
        do_reset();
        st0_valid = 1; st0_addr = TOHOST; st0_data = 1;
        tick();
        set_idle();
        wb_valid = 1; wb_rd = 7;
        tick();
        set_idle();
        chk("t4_finish", finish, 1);
        repeat (3) tick();
        chk("t4_drained", drained, 1);

        // 5: watchdog
        do_reset();
        repeat (WLIM) tick();
        chk("t5_abort_pre", abort, 0);
        tick();
        chk("t5_abort", abort, 1);
        wb_valid = 1; wb_rd = 3;
        tick();
        set_idle();
        repeat (2) tick();

        // 6: x0 writebacks for 2000 cycles
        do_reset();
        n_pop = 0;
        wb_valid = 1; wb_rd = 0;
        for (int i = 0; i < 2000; i++) begin
            wb_data = $urandom;
            tick();
        end
        set_idle();
        repeat (3) tick();
        chk("t6_abort", abort, 0);
`ifdef TRACE_FILTER_X0_EN
        chk("t6_count", n_pop, 0);
`else
        chk("t6_count", n_pop, 2000);
`endif

        // random traffic, ending with a tohost store on the second-half port
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            tr_ready   = ($urandom_range(9) < 7);
            wb_valid   = ($urandom_range(2) == 0); wb_pc_load = $urandom_range(1);
            wb_rd      = 5'($urandom_range(31));   wb_data = $urandom; wb_tag = $urandom;
            wb_instr   = $urandom;                 wb_pc = $urandom;
            st0_valid  = ($urandom_range(3) == 0); st0_addr = $urandom & 32'h0FFF_FFFC;
            st0_data   = $urandom; st0_tag = $urandom; st0_instr = $urandom;
            st1_valid  = ($urandom_range(5) == 0); st1_addr = $urandom & 32'h0FFF_FFFC;
            st1_data   = $urandom; st1_tag = $urandom; st1_instr = $urandom;
            if (i == 1499) begin st1_valid = 1; st1_addr = TOHOST; end
            tick();
        end
        set_idle();
        tr_ready = 1;
        repeat (DEPTH + 4) tick();
        chk("rnd_drained", drained, 1);

        // reset in the middle of traffic discards queued records
        tr_ready = 0;
        wb_valid = 1; wb_rd = 9;
        repeat (5) tick();
        do_reset();
        tr_ready = 1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
